inscache: RTL and testbench
===========================

# inscache

Direct-mapped instruction cache that answers the fetch unit's per-cycle instruction requests and refills missing lines from the memory controller. It returns 32 bits starting at any halfword-aligned PC, so the fetcher can take either a 16-bit compressed or a 32-bit instruction. This includes 32-bit instructions that straddle two cache lines. It sits between the fetch unit (`out_PC`/`ask_for`/`give_you`/`g_ins`) and the memory controller's word-read port.

## Interface
- `INDEX_BITS`, default 4: number of lines is 2^INDEX_BITS.
- `LINE_WORDS`, default 4: 32-bit words per line; fixed at 4, so a line is 16 bytes and offset is PC[3:0].
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset; **asynchronous, active-low**.
- `rdy_in`  in  1  global enable; when low, FSM, counters and arrays hold and `give_you`=0.
- `pc_in`  in  32  fetch PC, halfword aligned; driven by the fetcher's `out_PC`.
- `ask_for`  in  1  fetch request, level.
- `give_you`  out  1  `g_ins` is valid for the current `pc_in`.
- `g_ins`  out  32  instruction bits starting at `pc_in`.
- `mem_req`  out  1  word-read request, held high until `mem_done`.
- `mem_addr`  out  32  word-aligned read address.
- `mem_done`  in  1  one-cycle pulse: `mem_data` is valid.
- `mem_data`  in  32  returned word.

## Operation
- **Address split:** offset = PC[3:0]; index = PC[3+INDEX_BITS:4]; tag = PC[31:4+INDEX_BITS].
- **Line A and line B:**
  - Line A is the line at PC.
  - Line B is the next line: index+1, and tag+1 when the index wraps from all-ones to 0.
- **Straddle case:** PC[3:1]==3'b111 and A's last halfword has [1:0]==2'b11.
- **Hit:**
  - A is valid with matching tag, and
  - in the straddle case only, B is also valid with matching tag.
- **`g_ins` assembly:**
  - PC[1]==0: the word at PC.
  - PC[1]==1: {next halfword, upper half of the word at PC}.
  - The next halfword comes from A, or from B word 0 when PC[3:2]==3.
  - If the instruction is compressed and B misses, `g_ins[31:16]`=0.
- **Output logic:** `give_you` = `rdy_in` & `ask_for` & (state==IDLE) & hit. It is combinational from `pc_in` and the tag/valid arrays.
- **FSM states:**
  - IDLE: on `ask_for` & !hit, latch the fill line (A if A misses, else B), clear its valid bit, set word counter to 0, go to FILL.
  - FILL: drive `mem_req`=1 and `mem_addr`=line base + 4×counter. On `mem_done`, write `mem_data` into the word and increment the counter. On the 4th word, write the tag, set valid, drop `mem_req`, return to IDLE.
- **Two-line miss:** the straddle case with A and B both missing is handled as two sequential fills, A then B, by re-lookup in IDLE.
- **PC change mid-fill** (the fetcher redirected on ROB clear or jalr): the fill always completes and the line is installed. Lookup then uses the new PC; there is no abort toward memory.
- **`ask_for` low:** no new fill starts; a fill in progress completes.
- **Reset:** all valid bits 0, state IDLE, counter 0, `mem_req`=0, `mem_addr`=0. `give_you`=0 and `g_ins`=0 while the arrays are invalid. Reset asserted mid-fill aborts the fill immediately; the line stays invalid.

## Timing
- **Hit:** zero-cycle latency. The fetcher samples `give_you`/`g_ins` at the same edge it presents `pc_in`.
- **Miss:**
  - `mem_req` rises the edge after the miss is seen.
  - Each word costs the controller's latency plus one cycle.
  - Data is usable in the cycle after the final `mem_done`.
- **Memory handshake:**
  - `mem_addr` is stable while `mem_req`=1.
  - `mem_req` deasserts in the cycle after the last `mem_done`.
  - A `mem_done` seen while not in FILL is ignored.
- **Non-consumption:** the fetcher does not acknowledge. If it stalls (downstream full), it holds `pc_in` and the hit simply repeats.

## Structure
- `const.v` additions: `ICACHE_INDEX_BITS`, `ICACHE_LINE_WORDS`, FSM state encodings `IC_IDLE` and `IC_FILL`.
- Optional sub-module `icache_line_store`: holds the data, tag and valid arrays, with two read ports (A, B) and one write port. The FSM and assembly logic stay in `inscache`.

## Test plan
- **Cold miss:**
  - Reset, `ask_for`=1, PC=0x0.
  - Expect four `mem_req` reads at 0x0, 0x4, 0x8, 0xC.
  - Then `give_you`=1 with `g_ins`=mem[0x0].
- **Unaligned hit:** line 0 holds words 0x11112222, 0x33334444; PC=0x2 → `g_ins`=0x44441111.
- **Straddle:**
  - PC=0xE with a 32-bit instruction (low half [1:0]=11).
  - Expect fill of 0x10–0x1C, then `g_ins`={mem[0x10][15:0], mem[0xC][31:16]}.
  - With a compressed instruction instead: hit with no second fill, `g_ins[31:16]`=0.
- **Index wrap:**
  - PC=0xFE (index 15, offset 0xE), 32-bit instruction.
  - Line B is index 0 with tag 1: fill at 0x100.
- **Redirect mid-fill:**
  - Change PC to 0x40 after the 2nd word of a fill at 0x0.
  - The fill completes through 0xC; then 0x40 is filled.
  - `give_you` stays 0 until the 0x40 line is valid.
- **Async reset mid-fill:**
  - Assert `rst_in`=0 between two `mem_done` pulses.
  - Expect `mem_req`=0 immediately and the line invalid.
  - After release, the same PC refetches all 4 words.

Source files
------------

// File: rtl/inscache_pkg.sv
// ============================================================================
// Module  : inscache_pkg
// Brief   : Shared sizing, FSM encoding and helpers for the instruction cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inscache_pkg;

    localparam int ICACHE_INDEX_BITS = 4;
    localparam int ICACHE_LINE_WORDS = 4;

    typedef enum logic [0:0] {
        IC_IDLE = 1'b0,
        IC_FILL = 1'b1
    } ic_state_t;

    // A halfword whose two low bits are 11 starts a 32-bit instruction.
    function automatic logic is_full_len(input logic [1:0] lsb);
        return lsb == 2'b11;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inscache_if.sv
// ============================================================================
// Module  : inscache_if
// Brief   : Fetch-side and memory-side signals of the instruction cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface inscache_if;
    logic [31:0] pc_in;
    logic        ask_for;
    logic        give_you;
    logic [31:0] g_ins;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  pc_in, ask_for, mem_done, mem_data,
        output give_you, g_ins, mem_req, mem_addr
    );

    modport master (
        output pc_in, ask_for, mem_done, mem_data,
        input  give_you, g_ins, mem_req, mem_addr
    );
endinterface

`default_nettype wire

// File: rtl/inscache_line_store.sv
// ============================================================================
// Module  : inscache_line_store
// Brief   : Data/tag/valid arrays with two read ports (A, B) and one write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inscache_line_store #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 24
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  i_en,
    input  logic [INDEX_BITS-1:0] i_idx_a,
    input  logic [INDEX_BITS-1:0] i_idx_b,
    output logic                  o_valid_a,
    output logic                  o_valid_b,
    output logic [TAG_BITS-1:0]   o_tag_a,
    output logic [TAG_BITS-1:0]   o_tag_b,
    output logic [127:0]          o_line_a,
    output logic [15:0]           o_hw0_b,
    input  logic                  i_inv,
    input  logic [INDEX_BITS-1:0] i_inv_idx,
    input  logic                  i_wr,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic [1:0]            i_wr_word,
    input  logic [31:0]           i_wr_data,
    input  logic                  i_install,
    input  logic [TAG_BITS-1:0]   i_wr_tag
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [127:0]        r_data [LINES];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= '0;
        end else if (i_en) begin
            if (i_inv)     r_valid[i_inv_idx] <= 1'b0;
            if (i_install) r_valid[i_wr_idx]  <= 1'b1;
        end
    end

    // Payload arrays need no reset: nothing reads them while the valid bit is low.
    always_ff @(posedge clk_in) begin
        if (i_en) begin
            if (i_wr)      r_data[i_wr_idx][{i_wr_word, 5'b0} +: 32] <= i_wr_data;
            if (i_install) r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_valid_a = r_valid[i_idx_a];
    assign o_valid_b = r_valid[i_idx_b];
    assign o_tag_a   = r_tag[i_idx_a];
    assign o_tag_b   = r_tag[i_idx_b];
    assign o_line_a  = r_data[i_idx_a];
    assign o_hw0_b   = r_data[i_idx_b][15:0];

endmodule

`default_nettype wire

// File: rtl/inscache.sv
// ============================================================================
// Module  : inscache
// Brief   : Direct-mapped I-cache returning 32 bits at any halfword PC, with line refill.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inscache
    import inscache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    inscache_if.slave  bus
);

    localparam int TAG_BITS = 28 - INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] c_idx_one   = INDEX_BITS'(1);
    localparam logic [TAG_BITS-1:0]   c_tag_one   = TAG_BITS'(1);
    localparam logic [1:0]            c_last_word = 2'(LINE_WORDS - 1);

    ic_state_t             r_state;
    logic [1:0]            r_cnt;
    logic                  r_mem_req;
    logic [31:0]           r_mem_addr;
    logic [INDEX_BITS-1:0] r_fill_idx;
    logic [TAG_BITS-1:0]   r_fill_tag;

    logic [INDEX_BITS-1:0] w_idx_a, w_idx_b, w_fill_idx;
    logic [TAG_BITS-1:0]   w_tag_a, w_tag_b, w_fill_tag, w_st_tag_a, w_st_tag_b;
    logic                  w_valid_a, w_valid_b, w_a_hit, w_b_hit, w_straddle, w_hit;
    logic [127:0]          w_line_a;
    logic [15:0]           w_hw0_b, w_next_hw, w_upper;
    logic [1:0]            w_sel, w_sel_nxt, w_cnt_nxt;
    logic [31:0]           w_word, w_asm;
    logic                  w_start, w_wr, w_install;

    // Line B is the sequentially next line; the tag carries when the index wraps.
    assign w_idx_a = bus.pc_in[3+INDEX_BITS:4];
    assign w_tag_a = bus.pc_in[31:4+INDEX_BITS];
    assign w_idx_b = w_idx_a + c_idx_one;
    assign w_tag_b = (&w_idx_a) ? (w_tag_a + c_tag_one) : w_tag_a;

    assign w_a_hit    = w_valid_a && (w_st_tag_a == w_tag_a);
    assign w_b_hit    = w_valid_b && (w_st_tag_b == w_tag_b);
    assign w_straddle = (bus.pc_in[3:1] == 3'b111) && is_full_len(w_line_a[113:112]);
    assign w_hit      = w_a_hit && (!w_straddle || w_b_hit);

    assign w_sel     = bus.pc_in[3:2];
    assign w_sel_nxt = w_sel + 2'd1;
    assign w_word    = w_line_a[{w_sel, 5'b0} +: 32];
    assign w_next_hw = (w_sel == 2'd3) ? w_hw0_b : w_line_a[{w_sel_nxt, 5'b0} +: 16];
    // A compressed instruction at the end of the line may be served without line B.
    assign w_upper   = ((w_sel == 2'd3) && !w_b_hit) ? 16'h0 : w_next_hw;
    assign w_asm     = bus.pc_in[1] ? {w_upper, w_word[31:16]} : w_word;

    assign bus.g_ins    = w_hit ? w_asm : 32'h0;
    assign bus.give_you = rdy_in && bus.ask_for && (r_state == IC_IDLE) && w_hit;
    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;

    assign w_fill_idx = w_a_hit ? w_idx_b : w_idx_a;
    assign w_fill_tag = w_a_hit ? w_tag_b : w_tag_a;
    assign w_start    = rdy_in && (r_state == IC_IDLE) && bus.ask_for && !w_hit;
    assign w_wr       = (r_state == IC_FILL) && bus.mem_done;
    assign w_install  = w_wr && (r_cnt == c_last_word);
    assign w_cnt_nxt  = r_cnt + 2'd1;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= IC_IDLE;
            r_cnt      <= 2'd0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
            r_fill_idx <= '0;
            r_fill_tag <= '0;
        end else if (rdy_in) begin
            case (r_state)
                IC_IDLE: begin
                    if (bus.ask_for && !w_hit) begin
                        r_fill_idx <= w_fill_idx;
                        r_fill_tag <= w_fill_tag;
                        r_cnt      <= 2'd0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {w_fill_tag, w_fill_idx, 4'b0};
                        r_state    <= IC_FILL;
                    end
                end
                IC_FILL: begin
                    if (bus.mem_done) begin
                        r_cnt <= w_cnt_nxt;
                        if (r_cnt == c_last_word) begin
                            r_mem_req <= 1'b0;
                            r_state   <= IC_IDLE;
                        end else begin
                            r_mem_addr <= {r_fill_tag, r_fill_idx, w_cnt_nxt, 2'b00};
                        end
                    end
                end
                default: r_state <= IC_IDLE;
            endcase
        end
    end

    inscache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_en      (rdy_in),
        .i_idx_a   (w_idx_a),
        .i_idx_b   (w_idx_b),
        .o_valid_a (w_valid_a),
        .o_valid_b (w_valid_b),
        .o_tag_a   (w_st_tag_a),
        .o_tag_b   (w_st_tag_b),
        .o_line_a  (w_line_a),
        .o_hw0_b   (w_hw0_b),
        .i_inv     (w_start),
        .i_inv_idx (w_fill_idx),
        .i_wr      (w_wr),
        .i_wr_idx  (r_fill_idx),
        .i_wr_word (r_cnt),
        .i_wr_data (bus.mem_data),
        .i_install (w_install),
        .i_wr_tag  (r_fill_tag)
    );

endmodule

`default_nettype wire

// File: tb/tb_inscache.sv
// ============================================================================
// Module  : tb_inscache
// Brief   : Directed and random fetch traffic against a line-level cache/memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inscache;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;

    inscache_if bus_if();

    inscache dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int dly      = 0;
    bit last_gv  = 1'b0;

    logic [31:0] mem_ovr [logic [31:0]];

    // Model: set of resident line base addresses plus the fill in progress.
    bit          mv [16];
    logic [31:0] mt [16];
    bit          m_fill = 1'b0;
    logic [31:0] m_base = 32'h0;
    int          m_k    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] a4;
        a4 = {a[31:2], 2'b00};
        if (mem_ovr.exists(a4)) return mem_ovr[a4];
        return (a4 * 32'h9E3779B1) ^ 32'h2545F491;
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem_rd(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit present(input logic [31:0] base);
        return mv[base[7:4]] && (mt[base[7:4]] == base);
    endfunction

    function automatic bit needs_b(input logic [31:0] pc);
        logic [15:0] h;
        h = hw(pc);
        return (pc[3:1] == 3'b111) && (h[1:0] == 2'b11);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        logic [31:0] base;
        base = {pc[31:4], 4'h0};
        return present(base) && (!needs_b(pc) || present(base + 32'h10));
    endfunction

    function automatic logic [31:0] exp_ins(input logic [31:0] pc);
        logic [15:0] up;
        up = hw(pc + 32'd2);
        if ((pc[3:1] == 3'b111) && !present({pc[31:4], 4'h0} + 32'h10)) up = 16'h0;
        return {up, hw(pc)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            mt[i] = 32'h0;
        end
        m_fill = 1'b0;
        m_k    = 0;
    endtask

    // One clock: memory responds, outputs are checked, the model advances.
    task automatic step();
        logic [31:0] pc, a;
        bit          exp_gv;
        if (bus_if.mem_req) begin
            if (dly == 0) begin
                bus_if.mem_done = 1'b1;
                bus_if.mem_data = mem_rd(bus_if.mem_addr);
                dly = $urandom_range(0, 2);
            end else begin
                dly--;
            end
        end
        #1;
        pc     = bus_if.pc_in;
        exp_gv = rdy && bus_if.ask_for && !m_fill && m_hit(pc);
        last_gv = bus_if.give_you;
        check_val("give_you", {31'h0, bus_if.give_you}, {31'h0, exp_gv});
        if (exp_gv) check_val("g_ins", bus_if.g_ins, exp_ins(pc));
        check_val("mem_req", {31'h0, bus_if.mem_req}, {31'h0, m_fill});
        if (m_fill) check_val("mem_addr", bus_if.mem_addr, m_base + 32'(4 * m_k));
        if (rdy) begin
            if (!m_fill) begin
                if (bus_if.ask_for && !m_hit(pc)) begin
                    a = {pc[31:4], 4'h0};
                    m_base = present(a) ? a + 32'h10 : a;
                    mv[m_base[7:4]] = 1'b0;
                    m_fill = 1'b1;
                    m_k    = 0;
                end
            end else if (bus_if.mem_done) begin
                n_done++;
                m_k++;
                if (m_k == 4) begin
                    mv[m_base[7:4]] = 1'b1;
                    mt[m_base[7:4]] = m_base;
                    m_fill = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        bus_if.mem_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_hit(input string tag);
        last_gv = 1'b0;
        for (int i = 0; i < 300 && !last_gv; i++) step();
        check_val(tag, {31'h0, last_gv}, 32'h1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && n_done < target; i++) step();
        check_val("done_wait", n_done, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done;
        rst_n = 1'b0;
        rdy   = 1'b1;
        bus_if.pc_in    = 32'h0;
        bus_if.ask_for  = 1'b0;
        bus_if.mem_done = 1'b0;
        bus_if.mem_data = 32'h0;
        model_reset();
        mem_ovr[32'h00]  = 32'h1111_2222;
        mem_ovr[32'h04]  = 32'h3333_4444;
        mem_ovr[32'h0C]  = 32'hABC7_1234;
        mem_ovr[32'h10]  = 32'h5555_6666;
        mem_ovr[32'h2C]  = 32'h5678_0000;
        mem_ovr[32'hFC]  = 32'hDEF3_0000;
        mem_ovr[32'h100] = 32'hCAFE_BEEF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_give_you", {31'h0, bus_if.give_you}, 32'h0);
        check_val("rst_g_ins", bus_if.g_ins, 32'h0);
        check_val("rst_mem_req", {31'h0, bus_if.mem_req}, 32'h0);
        check_val("rst_mem_addr", bus_if.mem_addr, 32'h0);
        @(negedge clk);

        // Cold miss at 0x0
        base_done = n_done;
        bus_if.ask_for = 1'b1;
        bus_if.pc_in   = 32'h0;
        wait_hit("cold_hit");
        check_val("cold_words", n_done - base_done, 4);
        check_val("cold_g_ins", bus_if.g_ins, 32'h1111_2222);

        // Unaligned hit in the same line
        bus_if.pc_in = 32'h2;
        #1;
        check_val("unaligned_gv", {31'h0, bus_if.give_you}, 32'h1);
        check_val("unaligned_g_ins", bus_if.g_ins, 32'h4444_1111);
        step();

        // Straddle with a 32-bit instruction pulls in line 0x10
        base_done = n_done;
        bus_if.pc_in = 32'hE;
        wait_hit("straddle_hit");
        check_val("straddle_words", n_done - base_done, 4);
        check_val("straddle_g_ins", bus_if.g_ins, 32'h6666_ABC7);

        // Compressed at end of line 0x20 needs no line B
        bus_if.pc_in = 32'h20;
        wait_hit("rvc_line_hit");
        bus_if.pc_in = 32'h2E;
        #1;
        check_val("rvc_gv", {31'h0, bus_if.give_you}, 32'h1);
        check_val("rvc_g_ins", bus_if.g_ins, 32'h0000_5678);
        step();
        check_val("rvc_no_fill", {31'h0, bus_if.mem_req}, 32'h0);

        // Index wrap: 0xF0 then 0x100 (index 0, tag 1)
        base_done = n_done;
        bus_if.pc_in = 32'hFE;
        wait_hit("wrap_hit");
        check_val("wrap_words", n_done - base_done, 8);
        check_val("wrap_g_ins", bus_if.g_ins, 32'hBEEF_DEF3);

        // Redirect to 0x40 after two words of the 0x0 refill
        base_done = n_done;
        bus_if.pc_in = 32'h0;
        wait_done(base_done + 2);
        bus_if.pc_in = 32'h40;
        wait_hit("redirect_hit");
        check_val("redirect_words", n_done - base_done, 8);
        check_val("redirect_g_ins", bus_if.g_ins, mem_rd(32'h40));

        // Async reset between two mem_done pulses
        base_done = n_done;
        bus_if.pc_in = 32'h80;
        wait_done(base_done + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_mem_req", {31'h0, bus_if.mem_req}, 32'h0);
        check_val("arst_mem_addr", bus_if.mem_addr, 32'h0);
        check_val("arst_give_you", {31'h0, bus_if.give_you}, 32'h0);
        model_reset();
        dly = 0;
        @(negedge clk);
        rst_n = 1'b1;
        base_done = n_done;
        wait_hit("arst_refetch_hit");
        check_val("arst_refetch_words", n_done - base_done, 4);
        check_val("arst_g_ins", bus_if.g_ins, mem_rd(32'h80));

        // Random traffic: held PCs, redirects, request gaps and stalls
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 9) != 0);
            bus_if.ask_for = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0)
                bus_if.pc_in = 32'($urandom_range(0, 511)) << 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
